// File: rtl/lcd_write_queue.sv
// Rate-matching character queue between the processor LCD write port and the
// LCD controller: buffers bytes in a FIFO and replays them as spaced pulses.
module lcd_write_queue #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_write_en,
    input  logic [31:0]              in_write_data,
    output logic                     out_write_en,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [GW-1:0]   gap_cnt, gap_next;
    logic [CW-1:0]   count_next;
    logic            push, pop, load_out;

    logic unused_upper_bits;
    assign unused_upper_bits = ^in_write_data[31:8];

    assign out_write_en = (state == ISSUE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        gap_next   = gap_cnt;
        load_out   = 1'b0;
        pop        = (state == ISSUE);
        push       = in_write_en && (!full || pop);

        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = ISSUE;
                    load_out   = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                gap_next   = GW'(GAP_CYCLES - 1);
            end
            WAIT: begin
                if (gap_cnt == '0) state_next = IDLE;
                else               gap_next   = gap_cnt - GW'(1);
            end
            default: state_next = IDLE;
        endcase

        count_next = count;
        if (push && !pop)      count_next = count + CW'(1);
        else if (pop && !push) count_next = count - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            gap_cnt  <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            out_data <= 8'h00;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            count   <= count_next;
            full    <= (count_next == CW'(DEPTH));
            empty   <= (count_next == '0);
            if (push)                overflow <= overflow;
            if (push)                wr_ptr   <= wr_ptr + AW'(1);
            if (pop)                 rd_ptr   <= rd_ptr + AW'(1);
            if (in_write_en && !push) overflow <= 1'b1;
            if (load_out)            out_data <= mem[rd_ptr];
        end
    end

    // A push while full can only land on the slot being popped, whose byte
    // was already copied to out_data when ISSUE was entered.
    // NOTE: storage array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_write_data[7:0];
    end

endmodule

// File: tb/tb_lcd_write_queue.sv
// Directed self-checking bench for lcd_write_queue with DEPTH=4, GAP_CYCLES=4.
module tb_lcd_write_queue;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int SPACE = GAP + 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_write_en;
    logic [31:0] in_write_data;
    logic        out_write_en;
    logic [7:0]  out_data;
    logic [2:0]  count;
    logic        full, empty, overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int max_count;
    int pulse_cyc [$];
    int pulse_dat [$];
    int w0;

    lcd_write_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_write_en  (in_write_en),
        .in_write_data(in_write_data),
        .out_write_en (out_write_en),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later and log any output pulse.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (out_write_en === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(int'(out_data));
        end
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic write(input logic [31:0] d);
        in_write_en   = 1'b1;
        in_write_data = d;
        step();
        in_write_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_dat.delete();
        max_count = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},   32'(out_write_en), 32'd0);
        check({tag, "_data"},  32'(out_data),     32'h00);
        check({tag, "_count"}, 32'(count),        32'd0);
        check({tag, "_full"},  32'(full),         32'd0);
        check({tag, "_empty"}, 32'(empty),        32'd1);
        check({tag, "_ovf"},   32'(overflow),     32'd0);
    endtask

    // Mid-cycle asynchronous reset pulse, sampled before any clock edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_reset_outputs(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        in_write_en   = 1'b0;
        in_write_data = 32'h0;
        clear_log();

        // Reset state, observed before the first clock edge
        #2 reset = 1'b1;
        #2 check_reset_outputs("por");
        idle(2);
        #3 reset = 1'b0;
        idle(2);

        // Single write: pulse one cycle later, pop on the following edge
        clear_log();
        in_write_en = 1'b1; in_write_data = 32'h0000_0041;
        step();
        in_write_en = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_empty_after_push", 32'(empty), 32'd0);
        check("single_no_pulse_yet", 32'(out_write_en), 32'd0);
        step();
        check("single_pulse", 32'(out_write_en), 32'd1);
        check("single_data", 32'(out_data), 32'h41);
        step();
        check("single_pulse_ends", 32'(out_write_en), 32'd0);
        check("single_count_popped", 32'(count), 32'd0);
        check("single_empty_popped", 32'(empty), 32'd1);
        idle(10);
        check("single_one_pulse", 32'(pulse_cyc.size()), 32'd1);

        // Burst of three: pulses 1, 7, 13 edges after the first write
        clear_log();
        w0 = cyc + 1;
        write(32'h41); write(32'h42); write(32'h43);
        idle(20);
        check("burst_pulses", 32'(pulse_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < pulse_cyc.size(); i++) begin
            check($sformatf("burst_cyc%0d", i), 32'(pulse_cyc[i]), 32'(w0 + 1 + SPACE * i));
            check($sformatf("burst_dat%0d", i), 32'(pulse_dat[i]), 32'h41 + 32'(i));
        end
        check("burst_peak_count", 32'(max_count), 32'd2);
        check("burst_no_overflow", 32'(overflow), 32'd0);
        check("burst_empty", 32'(empty), 32'd1);

        // Six back-to-back writes into a 4-deep queue: the last is dropped
        clear_log();
        w0 = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            write(32'h30 + 32'(i));
            if (i == 2) check("ovf6_count_after_pop", 32'(count), 32'd2);
            if (i == 4) begin
                check("ovf6_full_before_drop", 32'(full), 32'd1);
                check("ovf6_no_ovf_yet", 32'(overflow), 32'd0);
            end
            if (i == 5) begin
                check("ovf6_overflow_set", 32'(overflow), 32'd1);
                check("ovf6_count_held", 32'(count), 32'd4);
            end
        end
        idle(34);
        check("ovf6_pulses", 32'(pulse_cyc.size()), 32'd5);
        for (int i = 0; i < 5 && i < pulse_cyc.size(); i++) begin
            check($sformatf("ovf6_cyc%0d", i), 32'(pulse_cyc[i]), 32'(w0 + 1 + SPACE * i));
            check($sformatf("ovf6_dat%0d", i), 32'(pulse_dat[i]), 32'h30 + 32'(i));
        end
        check("ovf6_sticky", 32'(overflow), 32'd1);
        check("ovf6_empty", 32'(empty), 32'd1);
        async_reset("rst_clear_ovf");
        idle(2);

        // Push while full on the same edge as the ISSUE pop
        clear_log();
        w0 = cyc + 1;
        for (int i = 0; i < 5; i++) write(32'hA0 + 32'(i));
        check("pwf_full", 32'(full), 32'd1);
        idle(3);
        check("pwf_in_issue", 32'(out_write_en), 32'd1);
        check("pwf_full_in_issue", 32'(full), 32'd1);
        write(32'hA5);
        check("pwf_count_stays", 32'(count), 32'd4);
        check("pwf_full_stays", 32'(full), 32'd1);
        check("pwf_no_overflow", 32'(overflow), 32'd0);
        idle(32);
        check("pwf_pulses", 32'(pulse_cyc.size()), 32'd6);
        for (int i = 0; i < 6 && i < pulse_dat.size(); i++)
            check($sformatf("pwf_dat%0d", i), 32'(pulse_dat[i]), 32'hA0 + 32'(i));
        check("pwf_empty", 32'(empty), 32'd1);

        // Upper bytes are ignored
        clear_log();
        write(32'hDEAD_BE7A);
        idle(8);
        check("mask_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_dat.size() > 0) check("mask_data", 32'(pulse_dat[0]), 32'h7A);

        // Asynchronous reset mid-WAIT with two entries queued
        clear_log();
        write(32'h61); write(32'h62); write(32'h63);
        step();
        check("rst_mid_count", 32'(count), 32'd2);
        check("rst_mid_data", 32'(out_data), 32'h61);
        async_reset("rst_mid");
        clear_log();
        idle(12);
        check("rst_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        w0 = cyc + 1;
        write(32'h55);
        idle(8);
        check("rst_new_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() > 0) begin
            check("rst_new_latency", 32'(pulse_cyc[0]), 32'(w0 + 1));
            check("rst_new_data", 32'(pulse_dat[0]), 32'h55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
